// File: rtl/mesi_cpu_req_fsm.sv
// CPU-side MESI request controller for a direct-mapped L1 line array.
// Optional bus response timeout: define CPU_REQ_BUS_TIMEOUT_EN.
`ifndef INVALID
`define INVALID              3'd0
`define SHARED               3'd1
`define EXCLUSIVE            3'd2
`define MODIFIED             3'd3
`endif
`ifndef BUS_NO_REQ
`define BUS_NO_REQ           2'd0
`define BUS_READ_REQ         2'd1
`define BUS_RWITM_REQ        2'd2
`define BUS_INVALIDATE_REQ   2'd3
`endif
`ifndef BUS_NO_RSP
`define BUS_NO_RSP           2'd0
`define BUS_SNOOP_FOUND_RSP  2'd1
`define BUS_FETCH_MEM_RSP    2'd2
`endif

module mesi_cpu_req_fsm #(
  parameter int ADDR_W         = 16,
  parameter int NUM_LINES      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req_valid,
  output logic                         cpu_req_ready,
  input  logic                         cpu_req_wr,
  input  logic [ADDR_W-1:0]            cpu_req_addr,
  output logic                         cpu_rsp_valid,
  output logic                         cpu_rsp_hit,
  output logic                         cpu_rsp_err,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [ADDR_W-1:0]            wb_addr,
  output logic                         bus_req_valid,
  input  logic                         bus_req_ready,
  output logic [1:0]                   bus_req_type,
  output logic [ADDR_W-1:0]            bus_req_addr,
  input  logic [1:0]                   bus_rsp,
  input  logic [$clog2(NUM_LINES)-1:0] dbg_idx,
  output logic [2:0]                   dbg_state
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_BUS_REQ, S_BUS_WAIT, S_RESP} fsm_t;
  fsm_t fsm_q, fsm_d;

  logic                           req_wr_q;
  logic [ADDR_W-1:0]              req_addr_q;
  logic                           hit_q, hit_d;
  logic [1:0]                     type_q, type_d;
  logic [NUM_LINES-1:0][2:0]      line_st_q;
  logic [NUM_LINES-1:0][TAG_W-1:0] line_tag_q;
  logic                           upd_st_en, upd_tag_en;
  logic [2:0]                     upd_st;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       cur_st;
  logic             lookup_hit, rsp_ok;

  assign idx        = req_addr_q[IDX_W-1:0];
  assign tag        = req_addr_q[ADDR_W-1:IDX_W];
  assign cur_st     = line_st_q[idx];
  assign lookup_hit = (cur_st != `INVALID) && (line_tag_q[idx] == tag);
  // Undefined response codes fall through as "no response".
  assign rsp_ok     = (bus_rsp == `BUS_SNOOP_FOUND_RSP) || (bus_rsp == `BUS_FETCH_MEM_RSP);

`ifdef CPU_REQ_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q, err_d, tmo_hit;
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    fsm_d      = fsm_q;
    hit_d      = hit_q;
    type_d     = type_q;
    upd_st_en  = 1'b0;
    upd_tag_en = 1'b0;
    upd_st     = `INVALID;
`ifdef CPU_REQ_BUS_TIMEOUT_EN
    err_d      = err_q;
`endif
    case (fsm_q)
      S_IDLE: if (cpu_req_valid) begin
        fsm_d = S_LOOKUP;
        hit_d = 1'b0;
`ifdef CPU_REQ_BUS_TIMEOUT_EN
        err_d = 1'b0;
`endif
      end
      S_LOOKUP: begin
        hit_d = lookup_hit;
        if (lookup_hit && !req_wr_q) begin
          fsm_d = S_RESP;
        end else if (lookup_hit && cur_st != `SHARED) begin
          upd_st_en = 1'b1;
          upd_st    = `MODIFIED;
          fsm_d     = S_RESP;
        end else if (lookup_hit) begin
          type_d = `BUS_INVALIDATE_REQ;
          fsm_d  = S_BUS_REQ;
        end else begin
          type_d = req_wr_q ? `BUS_RWITM_REQ : `BUS_READ_REQ;
          fsm_d  = (cur_st == `MODIFIED) ? S_WB : S_BUS_REQ;
        end
      end
      S_WB:      if (wb_ready)      fsm_d = S_BUS_REQ;
      S_BUS_REQ: if (bus_req_ready) fsm_d = S_BUS_WAIT;
      S_BUS_WAIT: begin
        if (rsp_ok) begin
          upd_st_en  = 1'b1;
          upd_tag_en = 1'b1;
          if (type_q == `BUS_READ_REQ)
            upd_st = (bus_rsp == `BUS_SNOOP_FOUND_RSP) ? `SHARED : `EXCLUSIVE;
          else
            upd_st = `MODIFIED;
          fsm_d = S_RESP;
        end
`ifdef CPU_REQ_BUS_TIMEOUT_EN
        else if (tmo_hit) begin
          // Line is dropped even if it was SHARED; tag kept as-is.
          upd_st_en = 1'b1;
          upd_st    = `INVALID;
          err_d     = 1'b1;
          fsm_d     = S_RESP;
        end
`endif
      end
      S_RESP:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      req_wr_q   <= 1'b0;
      req_addr_q <= '0;
      hit_q      <= 1'b0;
      type_q     <= `BUS_NO_REQ;
      for (int i = 0; i < NUM_LINES; i++) line_st_q[i] <= `INVALID;
      line_tag_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      hit_q  <= hit_d;
      type_q <= type_d;
      if (fsm_q == S_IDLE && cpu_req_valid) begin
        req_wr_q   <= cpu_req_wr;
        req_addr_q <= cpu_req_addr;
      end
      if (upd_st_en)  line_st_q[idx]  <= upd_st;
      if (upd_tag_en) line_tag_q[idx] <= tag;
    end
  end

`ifdef CPU_REQ_BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q     <= err_d;
      tmo_cnt_q <= (fsm_q == S_BUS_WAIT) ? tmo_cnt_q + 1'b1 : '0;
    end
  end
  assign cpu_rsp_err = (fsm_q == S_RESP) & err_q;
`else
  assign cpu_rsp_err = 1'b0;
`endif

  assign cpu_req_ready = (fsm_q == S_IDLE);
  assign cpu_rsp_valid = (fsm_q == S_RESP);
  assign cpu_rsp_hit   = (fsm_q == S_RESP) & hit_q;
  assign wb_valid      = (fsm_q == S_WB);
  assign wb_addr       = wb_valid ? {line_tag_q[idx], idx} : '0;
  assign bus_req_valid = (fsm_q == S_BUS_REQ);
  assign bus_req_type  = bus_req_valid ? type_q : `BUS_NO_REQ;
  assign bus_req_addr  = bus_req_valid ? req_addr_q : '0;
  assign dbg_state     = line_st_q[dbg_idx];

endmodule

// File: tb/tb_mesi_cpu_req_fsm.sv
// Cycle-timeline bench for mesi_cpu_req_fsm: a transaction model builds the
// expected per-cycle outputs from latency rules; one process compares them.
`ifndef INVALID
`define INVALID              3'd0
`define SHARED               3'd1
`define EXCLUSIVE            3'd2
`define MODIFIED             3'd3
`endif
`ifndef BUS_NO_REQ
`define BUS_NO_REQ           2'd0
`define BUS_READ_REQ         2'd1
`define BUS_RWITM_REQ        2'd2
`define BUS_INVALIDATE_REQ   2'd3
`endif
`ifndef BUS_NO_RSP
`define BUS_NO_RSP           2'd0
`define BUS_SNOOP_FOUND_RSP  2'd1
`define BUS_FETCH_MEM_RSP    2'd2
`endif

module tb_mesi_cpu_req_fsm;
`ifdef CPU_REQ_BUS_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 1 << 30;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        cpu_req_valid = 1'b0, cpu_req_wr = 1'b0;
  logic [15:0] cpu_req_addr = '0;
  logic        cpu_req_ready, cpu_rsp_valid, cpu_rsp_hit, cpu_rsp_err;
  logic        wb_valid, wb_ready = 1'b0;
  logic [15:0] wb_addr, bus_req_addr;
  logic        bus_req_valid, bus_req_ready = 1'b0;
  logic [1:0]  bus_req_type, bus_rsp = `BUS_NO_RSP;
  logic [2:0]  dbg_idx = '0, dbg_state;

  mesi_cpu_req_fsm #(.ADDR_W(16), .NUM_LINES(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_wr(cpu_req_wr), .cpu_req_addr(cpu_req_addr),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_hit(cpu_rsp_hit), .cpu_rsp_err(cpu_rsp_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_type(bus_req_type), .bus_req_addr(bus_req_addr),
    .bus_rsp(bus_rsp), .dbg_idx(dbg_idx), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rdy, rv, rh, re, wv, bv;
    logic [15:0] wa, ba;
    logic [1:0]  bt;
    logic [2:0]  dbg;
    logic cv, cw, wr_rdy, br_rdy;
    logic [15:0] ca;
    logic [1:0]  rsp;
    logic [2:0]  didx;
  } cyc_t;

  cyc_t exp_q[$];
  cyc_t e;
  int   n_chk = 0, n_fail = 0;
  logic [2:0]  m_st[8];
  logic [12:0] m_tg[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cpu_req_ready", cpu_req_ready, e.rdy);
      chk("cpu_rsp_valid", cpu_rsp_valid, e.rv);
      chk("cpu_rsp_hit",   cpu_rsp_hit,   e.rh);
      chk("cpu_rsp_err",   cpu_rsp_err,   e.re);
      chk("wb_valid",      wb_valid,      e.wv);
      if (e.wv) chk("wb_addr", wb_addr, e.wa);
      chk("bus_req_valid", bus_req_valid, e.bv);
      if (e.bv) chk("bus_req_addr", bus_req_addr, e.ba);
      if (e.bv || e.rdy) chk("bus_req_type", bus_req_type, e.bt);
      chk("dbg_state", dbg_state, e.dbg);
    end
  end

  function automatic cyc_t blank(input logic [2:0] i);
    cyc_t c;
    c = '{rdy:1'b0, rv:1'b0, rh:1'b0, re:1'b0, wv:1'b0, bv:1'b0, wa:16'h0, ba:16'h0,
          bt:`BUS_NO_REQ, dbg:m_st[i], cv:1'b0, cw:1'b0, wr_rdy:1'b0, br_rdy:1'b0,
          ca:16'h0, rsp:`BUS_NO_RSP, didx:i};
    return c;
  endfunction

  task automatic step(input cyc_t c);
    @(posedge clk); #1;
    cpu_req_valid = c.cv; cpu_req_wr = c.cw; cpu_req_addr = c.ca;
    wb_ready = c.wr_rdy; bus_req_ready = c.br_rdy; bus_rsp = c.rsp; dbg_idx = c.didx;
    exp_q.push_back(c);
  endtask

  // One full CPU transaction; bus_rsp carries rsp_code outside the wait
  // window to show it is ignored there.
  task automatic do_req(input logic wr, input logic [15:0] addr, input int wb_stall,
                        input int req_stall, input int rsp_delay, input logic [1:0] rsp_code,
                        input logic [1:0] wait_code, output int ncyc);
    cyc_t c;
    logic [2:0] i, ost, nst;
    logic [12:0] tg;
    logic hit, err, upd_tag;
    logic [1:0] bt;
    i = addr[2:0]; tg = addr[15:3]; ost = m_st[i];
    hit = (ost != `INVALID) && (m_tg[i] == tg);
    err = 1'b0; upd_tag = 1'b0; ncyc = 0; nst = ost;
    c = blank(i); c.rdy = 1'b1; c.bt = `BUS_NO_REQ; c.cv = 1'b1; c.cw = wr; c.ca = addr; c.rsp = rsp_code;
    step(c); ncyc++;
    c = blank(i); c.rsp = rsp_code; step(c); ncyc++;
    if (hit && (!wr || ost == `EXCLUSIVE || ost == `MODIFIED)) begin
      nst = wr ? `MODIFIED : ost;
    end else begin
      bt = hit ? `BUS_INVALIDATE_REQ : (wr ? `BUS_RWITM_REQ : `BUS_READ_REQ);
      if (!hit && ost == `MODIFIED)
        for (int k = 0; k <= wb_stall; k++) begin
          c = blank(i); c.wv = 1'b1; c.wa = {m_tg[i], i}; c.wr_rdy = (k == wb_stall);
          c.rsp = rsp_code; step(c); ncyc++;
        end
      for (int k = 0; k <= req_stall; k++) begin
        c = blank(i); c.bv = 1'b1; c.bt = bt; c.ba = addr; c.br_rdy = (k == req_stall);
        c.rsp = rsp_code; step(c); ncyc++;
      end
      for (int k = 0; k < rsp_delay && k < TMO; k++) begin
        c = blank(i); c.rsp = wait_code; step(c); ncyc++;
      end
      if (rsp_delay >= TMO) begin
        err = 1'b1; nst = `INVALID;
      end else begin
        c = blank(i); c.rsp = rsp_code; step(c); ncyc++;
        nst = (bt == `BUS_READ_REQ) ?
              ((rsp_code == `BUS_SNOOP_FOUND_RSP) ? `SHARED : `EXCLUSIVE) : `MODIFIED;
        upd_tag = 1'b1;
      end
    end
    c = blank(i); c.rv = 1'b1; c.rh = hit; c.re = err; c.dbg = nst; step(c); ncyc++;
    m_st[i] = nst;
    if (upd_tag) m_tg[i] = tg;
  endtask

  task automatic lit_state(input string nm, input logic [2:0] i, input logic [2:0] lit);
    cyc_t c;
    c = blank(i); c.rdy = 1'b1; step(c);
    @(negedge clk); #1;
    chk(nm, dbg_state, lit);
  endtask

  task automatic chk_reset_state(input string nm);
    @(negedge clk);
    chk({nm, "_ready"}, cpu_req_ready, 1'b1);
    chk({nm, "_rsp_valid"}, cpu_rsp_valid, 1'b0);
    chk({nm, "_rsp_hit"}, cpu_rsp_hit, 1'b0);
    chk({nm, "_rsp_err"}, cpu_rsp_err, 1'b0);
    chk({nm, "_wb_valid"}, wb_valid, 1'b0);
    chk({nm, "_bus_valid"}, bus_req_valid, 1'b0);
    chk({nm, "_bus_type"}, bus_req_type, `BUS_NO_REQ);
    for (int k = 0; k < 8; k++) begin
      dbg_idx = 3'(k); #1;
      chk({nm, "_dbg_state"}, dbg_state, `INVALID);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin m_st[k] = `INVALID; m_tg[k] = '0; end
  endtask

  initial begin
    int n;
    cyc_t c;
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    chk_reset_state("reset");

    do_req(1'b0, 16'h0013, 0, 0, 0, `BUS_FETCH_MEM_RSP, `BUS_NO_RSP, n);
    chk("read_miss_latency", n, 5);
    lit_state("read_miss_excl", 3'd3, `EXCLUSIVE);

    do_req(1'b1, 16'h0013, 0, 0, 0, `BUS_FETCH_MEM_RSP, `BUS_NO_RSP, n);
    chk("write_hit_latency", n, 3);
    lit_state("write_hit_mod", 3'd3, `MODIFIED);

    // Dirty victim with 2 wb stalls, then an undefined code during the wait.
    do_req(1'b0, 16'h0023, 2, 0, 1, `BUS_SNOOP_FOUND_RSP, 2'd3, n);
    chk("wb_miss_latency", n, 9);
    lit_state("snoop_shared", 3'd3, `SHARED);

    do_req(1'b1, 16'h0023, 0, 5, 0, `BUS_FETCH_MEM_RSP, `BUS_NO_RSP, n);
    chk("upgrade_latency", n, 10);
    lit_state("upgrade_mod", 3'd3, `MODIFIED);

`ifdef CPU_REQ_BUS_TIMEOUT_EN
    do_req(1'b1, 16'h0045, 0, 0, 10, `BUS_FETCH_MEM_RSP, `BUS_NO_RSP, n);
    chk("timeout_latency", n, 8);
    lit_state("timeout_inval", 3'd5, `INVALID);
    do_req(1'b1, 16'h0045, 0, 0, 3, `BUS_FETCH_MEM_RSP, `BUS_NO_RSP, n);
    lit_state("expiry_rsp_wins", 3'd5, `MODIFIED);
`else
    do_req(1'b1, 16'h0045, 0, 0, 2, `BUS_FETCH_MEM_RSP, `BUS_NO_RSP, n);
    lit_state("rwitm_mod", 3'd5, `MODIFIED);
`endif

    // Back-to-back traffic across several lines.
    do_req(1'b0, 16'h0023, 0, 0, 0, `BUS_NO_RSP, `BUS_NO_RSP, n);
    do_req(1'b0, 16'h0006, 0, 1, 0, `BUS_SNOOP_FOUND_RSP, `BUS_NO_RSP, n);
    do_req(1'b1, 16'h0006, 0, 0, 1, `BUS_SNOOP_FOUND_RSP, `BUS_NO_RSP, n);
    do_req(1'b0, 16'h0045, 0, 0, 0, `BUS_NO_RSP, `BUS_NO_RSP, n);
    do_req(1'b1, 16'h0085, 1, 0, 0, `BUS_SNOOP_FOUND_RSP, `BUS_NO_RSP, n);
    do_req(1'b0, 16'h0011, 0, 0, 0, `BUS_FETCH_MEM_RSP, `BUS_NO_RSP, n);
    lit_state("line6_mod", 3'd6, `MODIFIED);

    // Abort a read miss on line 7 while it is waiting for the bus.
    c = blank(3'd7); c.rdy = 1'b1; c.cv = 1'b1; c.ca = 16'h0007; step(c);
    c = blank(3'd7); step(c);
    c = blank(3'd7); c.bv = 1'b1; c.bt = `BUS_READ_REQ; c.ba = 16'h0007; c.br_rdy = 1'b1; step(c);
    c = blank(3'd7); step(c);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    chk_reset_state("mid_reset");

    do_req(1'b0, 16'h0013, 0, 0, 0, `BUS_SNOOP_FOUND_RSP, `BUS_NO_RSP, n);
    chk("post_reset_miss_latency", n, 5);
    lit_state("post_reset_shared", 3'd3, `SHARED);

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
